// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types and constants: flag layout, stage-boundary structs,
// opcode encodings and the architectural reset values used by writeback.
package cpu_pkg;

   localparam int          NREGS       = 16;
   localparam logic [3:0]  RAX_IDX     = 4'd0;
   localparam logic [3:0]  RDX_IDX     = 4'd2;
   localparam logic [63:0] FLAGS_RESET = 64'h2;

   localparam logic [7:0] OPC_IMUL = 8'hF7;
   localparam logic [7:0] OPC_JE   = 8'h74;
   localparam logic [7:0] OPC_JNL  = 8'h7D;

   // RFLAGS bit layout, MSB first; res_1 is the always-one reserved bit.
   typedef struct packed {
      logic [51:0] rsvd_hi;
      logic        of_f;
      logic        df_f;
      logic        if_f;
      logic        tf_f;
      logic        sf_f;
      logic        zf_f;
      logic        res_5;
      logic        af_f;
      logic        res_3;
      logic        pf_f;
      logic        res_1;
      logic        cf_f;
   } flags_reg;

   typedef struct packed {
      logic        valid;
      logic [7:0]  opcode;
      logic [1:0]  dep;
      logic [3:0]  reg_byte;
      logic [3:0]  rm_byte;
      logic [63:0] operand_a;
      logic [63:0] operand_b;
      logic [63:0] mem_data;
      logic [63:0] rip;
      logic        sim_end;
   } MEM_EX;

   typedef struct packed {
      logic [7:0]  opcode;
      logic [1:0]  dep;
      logic [3:0]  reg_byte;
      logic [3:0]  rm_byte;
      logic [63:0] alu_result;
      logic [63:0] alu_ext_result;
      logic [63:0] rip;
      logic        jump_flag;
      logic [63:0] jump_target;
      logic        flags_valid;
      logic [63:0] rflags;
      logic        sim_end;
   } ex_wb_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WR_EXT = 2'd1,
      ST_HALT   = 2'd2
   } wb_state_e;

   function automatic logic is_jump(input logic [7:0] opc);
      return (opc == OPC_JE) || (opc == OPC_JNL);
   endfunction

   // dep == 2 means the result targets the ModRM reg field.
   function automatic logic [3:0] dest_sel(input logic [1:0] dep,
                                           input logic [3:0] reg_byte,
                                           input logic [3:0] rm_byte);
      return (dep == 2'd2) ? reg_byte : rm_byte;
   endfunction

endpackage

// File: rtl/mod_regfile.sv
// Architectural 16x64 register file: one synchronous write port, whole array
// visible as registered state, cleared by the asynchronous reset.
module mod_regfile
   import cpu_pkg::*;
(
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        we,
   input  logic [3:0]                  waddr,
   input  logic [63:0]                 wdata,
   output logic [NREGS-1:0][63:0]      regs
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         regs <= '0;
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

endmodule

// File: rtl/mod_writeback.sv
// Writeback stage: consumes one EX/WB entry per handshake, commits register,
// RFLAGS and RIP state, splits IMUL into two writes, redirects taken jumps.
//
// Handshake: an entry transfers on a rising edge where wb_valid && wb_ready;
// wb_ready depends only on registered state, and the producer holds the entry
// stable until it transfers.
module mod_writeback
   import cpu_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   wb_valid,
   output logic                   wb_ready,
   input  logic [7:0]             opcode_exwb,
   input  logic [1:0]             dep_exwb,
   input  logic [3:0]             regByte_exwb,
   input  logic [3:0]             rmByte_exwb,
   input  logic [63:0]            alu_result_exwb,
   input  logic [63:0]            alu_ext_result_exwb,
   input  logic [63:0]            rip_exwb,
   input  logic                   jump_flag_exwb,
   input  logic [63:0]            jump_target_exwb,
   input  logic                   flags_valid_exwb,
   input  logic [63:0]            rflags_exwb,
   input  logic                   sim_end_exwb,
   output logic [NREGS-1:0][63:0] regfile_o,
   output logic [63:0]            rflags_o,
   output logic [63:0]            rip_o,
   output logic                   redirect_valid,
   output logic [63:0]            redirect_target,
   output logic                   clr_valid,
   output logic [3:0]             clr_reg,
   output logic [63:0]            retired_count,
   output logic                   sim_done,
   output logic [1:0]             state_dbg
);

   ex_wb_t     entry;
   wb_state_e  state;
   logic [63:0] ext_q;
   logic        end_q;
   logic        accept;
   logic        jump;
   logic        imul;
   logic [3:0]  dst;
   logic        rf_we;
   logic [3:0]  rf_waddr;
   logic [63:0] rf_wdata;

   assign entry.opcode         = opcode_exwb;
   assign entry.dep            = dep_exwb;
   assign entry.reg_byte       = regByte_exwb;
   assign entry.rm_byte        = rmByte_exwb;
   assign entry.alu_result     = alu_result_exwb;
   assign entry.alu_ext_result = alu_ext_result_exwb;
   assign entry.rip            = rip_exwb;
   assign entry.jump_flag      = jump_flag_exwb;
   assign entry.jump_target    = jump_target_exwb;
   assign entry.flags_valid    = flags_valid_exwb;
   assign entry.rflags         = rflags_exwb;
   assign entry.sim_end        = sim_end_exwb;

   assign wb_ready  = (state == ST_IDLE);
   assign accept    = wb_valid && wb_ready;
   assign jump      = is_jump(entry.opcode);
   assign imul      = (entry.opcode == OPC_IMUL);
   assign dst       = imul ? RAX_IDX : dest_sel(entry.dep, entry.reg_byte, entry.rm_byte);
   assign state_dbg = state;

   // The single write port serves the RDX half while in WR_EXT; no entry can
   // be accepted then, so the two sources never collide.
   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = dst;
      rf_wdata = entry.alu_result;
      if (state == ST_WR_EXT) begin
         rf_we    = 1'b1;
         rf_waddr = RDX_IDX;
         rf_wdata = ext_q;
      end else if (accept && !jump) begin
         rf_we = 1'b1;
      end
   end

   mod_regfile u_regfile (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (rf_we),
      .waddr   (rf_waddr),
      .wdata   (rf_wdata),
      .regs    (regfile_o)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= ST_IDLE;
         ext_q           <= '0;
         end_q           <= 1'b0;
         rflags_o        <= FLAGS_RESET;
         rip_o           <= '0;
         retired_count   <= '0;
         redirect_valid  <= 1'b0;
         redirect_target <= '0;
         clr_valid       <= 1'b0;
         clr_reg         <= '0;
         sim_done        <= 1'b0;
      end else begin
         redirect_valid <= 1'b0;
         clr_valid      <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  retired_count <= retired_count + 64'd1;
                  if (entry.flags_valid) begin
                     rflags_o <= entry.rflags;
                  end
                  if (jump && entry.jump_flag) begin
                     redirect_valid  <= 1'b1;
                     redirect_target <= entry.jump_target;
                     rip_o           <= entry.jump_target;
                  end else begin
                     rip_o <= entry.rip;
                  end
                  if (!jump) begin
                     clr_valid <= 1'b1;
                     clr_reg   <= dst;
                  end
                  if (imul) begin
                     ext_q <= entry.alu_ext_result;
                     end_q <= entry.sim_end;
                     state <= ST_WR_EXT;
                  end else if (entry.sim_end) begin
                     state    <= ST_HALT;
                     sim_done <= 1'b1;
                  end
               end
            end
            ST_WR_EXT: begin
               clr_valid <= 1'b1;
               clr_reg   <= RDX_IDX;
               if (end_q) begin
                  state    <= ST_HALT;
                  sim_done <= 1'b1;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_HALT: begin
               sim_done <= 1'b1;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mod_writeback.sv
// Bench for mod_writeback: directed and random EX/WB entries checked against an
// architectural model of the register file, RIP, RFLAGS and retire count.
module tb_mod_writeback;
   import cpu_pkg::*;

   logic                   clk = 1'b0;
   logic                   reset_n;
   logic                   wb_valid;
   logic                   wb_ready;
   logic [7:0]             opcode_exwb;
   logic [1:0]             dep_exwb;
   logic [3:0]             regByte_exwb;
   logic [3:0]             rmByte_exwb;
   logic [63:0]            alu_result_exwb;
   logic [63:0]            alu_ext_result_exwb;
   logic [63:0]            rip_exwb;
   logic                   jump_flag_exwb;
   logic [63:0]            jump_target_exwb;
   logic                   flags_valid_exwb;
   logic [63:0]            rflags_exwb;
   logic                   sim_end_exwb;
   logic [NREGS-1:0][63:0] regfile_o;
   logic [63:0]            rflags_o;
   logic [63:0]            rip_o;
   logic                   redirect_valid;
   logic [63:0]            redirect_target;
   logic                   clr_valid;
   logic [3:0]             clr_reg;
   logic [63:0]            retired_count;
   logic                   sim_done;
   logic [1:0]             state_dbg;

   always #5 clk = ~clk;

   mod_writeback dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .wb_valid            (wb_valid),
      .wb_ready            (wb_ready),
      .opcode_exwb         (opcode_exwb),
      .dep_exwb            (dep_exwb),
      .regByte_exwb        (regByte_exwb),
      .rmByte_exwb         (rmByte_exwb),
      .alu_result_exwb     (alu_result_exwb),
      .alu_ext_result_exwb (alu_ext_result_exwb),
      .rip_exwb            (rip_exwb),
      .jump_flag_exwb      (jump_flag_exwb),
      .jump_target_exwb    (jump_target_exwb),
      .flags_valid_exwb    (flags_valid_exwb),
      .rflags_exwb         (rflags_exwb),
      .sim_end_exwb        (sim_end_exwb),
      .regfile_o           (regfile_o),
      .rflags_o            (rflags_o),
      .rip_o               (rip_o),
      .redirect_valid      (redirect_valid),
      .redirect_target     (redirect_target),
      .clr_valid           (clr_valid),
      .clr_reg             (clr_reg),
      .retired_count       (retired_count),
      .sim_done            (sim_done),
      .state_dbg           (state_dbg)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Scoreboard: expected clr_reg sequence and expected redirect targets.
   logic [3:0]  exp_q[$];
   logic [63:0] redir_q[$];

   // Architectural model.
   logic [63:0] m_rf[16];
   logic [63:0] m_rip;
   logic [63:0] m_flags;
   logic [63:0] m_count;
   logic        m_halt;

   // Observations one cycle after an accept (middle of a two-cycle IMUL).
   logic        mid_ready;
   logic [63:0] mid_rf0;
   logic [63:0] mid_rf2;

   logic [3:0]  mon_reg;
   logic [63:0] mon_tgt;

   always @(negedge clk) begin
      if (reset_n && clr_valid) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL clr_pulse unexpected: got reg=%0d, none expected", clr_reg);
         end else begin
            mon_reg = exp_q.pop_front();
            if (clr_reg !== mon_reg) begin
               n_fail++;
               $display("FAIL clr_reg: got %0d expected %0d", clr_reg, mon_reg);
            end
         end
      end
      if (reset_n && redirect_valid) begin
         n_checks++;
         if (redir_q.size() == 0) begin
            n_fail++;
            $display("FAIL redirect_pulse unexpected: got target=%h, none expected", redirect_target);
         end else begin
            mon_tgt = redir_q.pop_front();
            if (redirect_target !== mon_tgt) begin
               n_fail++;
               $display("FAIL redirect_target: got %h expected %h", redirect_target, mon_tgt);
            end
         end
      end
   end

   function automatic ex_wb_t mk(input logic [7:0] opc, input logic [1:0] dep,
                                 input logic [3:0] rg, input logic [3:0] rm,
                                 input logic [63:0] res);
      ex_wb_t e;
      e                = '0;
      e.opcode         = opc;
      e.dep            = dep;
      e.reg_byte       = rg;
      e.rm_byte        = rm;
      e.alu_result     = res;
      e.rip            = {32'h0, $urandom};
      e.rflags         = {32'h0, $urandom};
      return e;
   endfunction

   task automatic apply_entry(input ex_wb_t e);
      opcode_exwb         = e.opcode;
      dep_exwb            = e.dep;
      regByte_exwb        = e.reg_byte;
      rmByte_exwb         = e.rm_byte;
      alu_result_exwb     = e.alu_result;
      alu_ext_result_exwb = e.alu_ext_result;
      rip_exwb            = e.rip;
      jump_flag_exwb      = e.jump_flag;
      jump_target_exwb    = e.jump_target;
      flags_valid_exwb    = e.flags_valid;
      rflags_exwb         = e.rflags;
      sim_end_exwb        = e.sim_end;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_rf[i] = '0;
      m_rip   = '0;
      m_flags = 64'h2;
      m_count = '0;
      m_halt  = 1'b0;
      exp_q.delete();
      redir_q.delete();
   endtask

   task automatic model_commit(input ex_wb_t e);
      logic [3:0] d;
      m_count = m_count + 1;
      if (e.opcode == 8'h74 || e.opcode == 8'h7D) begin
         if (e.jump_flag) begin
            m_rip = e.jump_target;
            redir_q.push_back(e.jump_target);
         end else begin
            m_rip = e.rip;
         end
      end else begin
         m_rip = e.rip;
         if (e.opcode == 8'hF7) begin
            m_rf[0] = e.alu_result;
            exp_q.push_back(4'd0);
            m_rf[2] = e.alu_ext_result;
            exp_q.push_back(4'd2);
         end else begin
            d = (e.dep == 2'd2) ? e.reg_byte : e.rm_byte;
            m_rf[d] = e.alu_result;
            exp_q.push_back(d);
         end
      end
      if (e.flags_valid) m_flags = e.rflags;
      if (e.sim_end) m_halt = 1'b1;
   endtask

   // Called at a negedge; returns at the negedge after the final commit edge.
   task automatic drive(input ex_wb_t e);
      int waited;
      apply_entry(e);
      wb_valid = 1'b1;
      waited   = 0;
      while (!wb_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!wb_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL drive_timeout: wb_ready=%b after %0d cycles, required 1", wb_ready, waited);
         wb_valid = 1'b0;
         return;
      end
      @(posedge clk);
      model_commit(e);
      @(negedge clk);
      wb_valid  = 1'b0;
      mid_ready = wb_ready;
      mid_rf0   = regfile_o[0];
      mid_rf2   = regfile_o[2];
      if (e.opcode == 8'hF7) @(negedge clk);
   endtask

   task automatic apply_reset();
      reset_n  = 1'b0;
      wb_valid = 1'b0;
      apply_entry('0);
      model_reset();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      apply_reset();
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (regfile_o[i] !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_reg%0d: got %h expected 0", i, regfile_o[i]);
         end
      end
      n_checks++;
      if (rflags_o !== 64'h2) begin n_fail++; $display("FAIL reset_rflags: got %h expected 2", rflags_o); end
      n_checks++;
      if (rip_o !== 64'h0) begin n_fail++; $display("FAIL reset_rip: got %h expected 0", rip_o); end
      n_checks++;
      if (retired_count !== 64'h0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", retired_count); end
      n_checks++;
      if ({wb_ready, sim_done, clr_valid, redirect_valid} !== 4'b1000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got ready/done/clr/redir=%b expected 1000",
                  {wb_ready, sim_done, clr_valid, redirect_valid});
      end
   endtask

   task automatic test_alu_write();
      ex_wb_t e;
      e = mk(8'hB8, 2'd0, 4'd7, 4'd3, 64'h1234);
      drive(e);
      n_checks++;
      if (regfile_o[3] !== 64'h1234) begin n_fail++; $display("FAIL alu_rm_dst: got %h expected 1234", regfile_o[3]); end
      n_checks++;
      if (retired_count !== 64'd1) begin n_fail++; $display("FAIL alu_count: got %0d expected 1", retired_count); end
      n_checks++;
      if (rflags_o !== 64'h2) begin n_fail++; $display("FAIL alu_rflags: got %h expected 2", rflags_o); end
      n_checks++;
      if (rip_o !== e.rip) begin n_fail++; $display("FAIL alu_rip: got %h expected %h", rip_o, e.rip); end
      e = mk(8'h01, 2'd2, 4'd7, 4'd9, 64'hDEAD_BEEF_0000_0001);
      drive(e);
      n_checks++;
      if (regfile_o[7] !== 64'hDEAD_BEEF_0000_0001) begin n_fail++; $display("FAIL alu_reg_dst: got %h expected deadbeef00000001", regfile_o[7]); end
      n_checks++;
      if (regfile_o[9] !== m_rf[9]) begin n_fail++; $display("FAIL alu_rm_untouched: got %h expected %h", regfile_o[9], m_rf[9]); end
   endtask

   task automatic test_imul();
      ex_wb_t     e;
      logic [63:0] old_rf2;
      logic [63:0] old_count;
      old_rf2   = m_rf[2];
      old_count = m_count;
      e = mk(8'hF7, 2'd0, 4'd5, 4'd6, 64'h5);
      e.alu_ext_result = 64'hFFFF_FFFF_FFFF_FFFF;
      drive(e);
      n_checks++;
      if (mid_ready !== 1'b0) begin n_fail++; $display("FAIL imul_ready_mid: got %b expected 0", mid_ready); end
      n_checks++;
      if (mid_rf0 !== 64'h5) begin n_fail++; $display("FAIL imul_rax_first: got %h expected 5", mid_rf0); end
      n_checks++;
      if (mid_rf2 !== old_rf2) begin n_fail++; $display("FAIL imul_rdx_early: got %h expected %h", mid_rf2, old_rf2); end
      n_checks++;
      if (regfile_o[2] !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL imul_rdx: got %h expected all ones", regfile_o[2]); end
      n_checks++;
      if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL imul_ready_after: got %b expected 1", wb_ready); end
      n_checks++;
      if (retired_count !== old_count + 64'd1) begin n_fail++; $display("FAIL imul_count: got %0d expected %0d", retired_count, old_count + 64'd1); end
   endtask

   task automatic test_jump();
      ex_wb_t e;
      e = mk(8'h74, 2'd0, 4'd1, 4'd1, 64'hAAAA);
      e.jump_flag   = 1'b1;
      e.jump_target = 64'h40_0100;
      drive(e);
      n_checks++;
      if (redirect_valid !== 1'b1 || redirect_target !== 64'h40_0100) begin
         n_fail++;
         $display("FAIL jump_taken_redirect: got v=%b t=%h expected v=1 t=400100", redirect_valid, redirect_target);
      end
      n_checks++;
      if (rip_o !== 64'h40_0100) begin n_fail++; $display("FAIL jump_taken_rip: got %h expected 400100", rip_o); end
      n_checks++;
      if (regfile_o[1] !== m_rf[1]) begin n_fail++; $display("FAIL jump_no_write: got %h expected %h", regfile_o[1], m_rf[1]); end
      e = mk(8'h74, 2'd0, 4'd1, 4'd1, 64'hBBBB);
      e.rip         = 64'h40_0010;
      e.jump_target = 64'h40_0200;
      drive(e);
      n_checks++;
      if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL jump_not_taken_redirect: got %b expected 0", redirect_valid); end
      n_checks++;
      if (rip_o !== 64'h40_0010) begin n_fail++; $display("FAIL jump_not_taken_rip: got %h expected 400010", rip_o); end
      e = mk(8'h7D, 2'd2, 4'd4, 4'd4, 64'hCCCC);
      e.jump_flag   = 1'b1;
      e.jump_target = 64'h40_0800;
      drive(e);
      n_checks++;
      if (rip_o !== 64'h40_0800 || regfile_o[4] !== m_rf[4]) begin
         n_fail++;
         $display("FAIL jnl_taken: got rip=%h r4=%h expected rip=400800 r4=%h", rip_o, regfile_o[4], m_rf[4]);
      end
   endtask

   task automatic test_flags();
      ex_wb_t e;
      e = mk(8'hB8, 2'd0, 4'd0, 4'd8, 64'h88);
      e.flags_valid = 1'b1;
      e.rflags      = 64'h42;
      drive(e);
      n_checks++;
      if (rflags_o !== 64'h42) begin n_fail++; $display("FAIL flags_commit: got %h expected 42", rflags_o); end
      e = mk(8'hB8, 2'd0, 4'd0, 4'd8, 64'h99);
      e.flags_valid = 1'b0;
      e.rflags      = 64'hFFFF;
      drive(e);
      n_checks++;
      if (rflags_o !== 64'h42) begin n_fail++; $display("FAIL flags_hold: got %h expected 42", rflags_o); end
   endtask

   task automatic test_random();
      logic [7:0] ops[8];
      ex_wb_t     e;
      ops = '{8'hB8, 8'h01, 8'h89, 8'hF7, 8'h74, 8'h7D, 8'h29, 8'h00};
      for (int n = 0; n < 40; n++) begin
         e = mk(ops[$urandom_range(0, 6)], 2'($urandom_range(0, 3)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                {$urandom, $urandom});
         if (n % 9 == 8) e.opcode = 8'($urandom_range(0, 255));
         e.alu_ext_result = {$urandom, $urandom};
         e.jump_flag      = 1'($urandom_range(0, 1));
         e.jump_target    = {32'h0, $urandom};
         e.flags_valid    = 1'($urandom_range(0, 1));
         drive(e);
         for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (regfile_o[i] !== m_rf[i]) begin
               n_fail++;
               $display("FAIL rand%0d_reg%0d: got %h expected %h", n, i, regfile_o[i], m_rf[i]);
            end
         end
         n_checks++;
         if (rip_o !== m_rip || rflags_o !== m_flags || retired_count !== m_count) begin
            n_fail++;
            $display("FAIL rand%0d_arch: got rip=%h fl=%h cnt=%0d expected rip=%h fl=%h cnt=%0d",
                     n, rip_o, rflags_o, retired_count, m_rip, m_flags, m_count);
         end
         n_checks++;
         if (wb_ready !== 1'b1 || sim_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rand%0d_ctrl: got ready=%b done=%b expected 1 0", n, wb_ready, sim_done);
         end
      end
   endtask

   task automatic test_reset_mid_imul();
      ex_wb_t e;
      e = mk(8'hF7, 2'd0, 4'd0, 4'd0, 64'h77);
      e.alu_ext_result = 64'hAAAA_5555_AAAA_5555;
      apply_entry(e);
      wb_valid = 1'b1;
      n_checks++;
      if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre_ready: got %b expected 1", wb_ready); end
      @(posedge clk);
      #2;
      reset_n  = 1'b0;
      wb_valid = 1'b0;
      model_reset();
      #1;
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (regfile_o[i] !== 64'h0) begin
            n_fail++;
            $display("FAIL rst_mid_async_reg%0d: got %h expected 0", i, regfile_o[i]);
         end
      end
      n_checks++;
      if (wb_ready !== 1'b1 || clr_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_async_ctrl: got ready=%b clr=%b expected 1 0", wb_ready, clr_valid);
      end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (regfile_o[2] !== 64'h0 || regfile_o[0] !== 64'h0) begin
         n_fail++;
         $display("FAIL rst_mid_rdx: got r0=%h r2=%h expected 0 0", regfile_o[0], regfile_o[2]);
      end
      n_checks++;
      if (wb_ready !== 1'b1 || retired_count !== 64'h0) begin
         n_fail++;
         $display("FAIL rst_mid_after: got ready=%b cnt=%0d expected 1 0", wb_ready, retired_count);
      end
   endtask

   task automatic test_sim_end();
      ex_wb_t     e;
      logic [63:0] old_r5;
      e = mk(8'hF7, 2'd0, 4'd0, 4'd0, 64'h1111);
      e.alu_ext_result = 64'h2222;
      e.sim_end        = 1'b1;
      drive(e);
      n_checks++;
      if (regfile_o[0] !== 64'h1111 || regfile_o[2] !== 64'h2222) begin
         n_fail++;
         $display("FAIL end_imul_writes: got r0=%h r2=%h expected 1111 2222", regfile_o[0], regfile_o[2]);
      end
      n_checks++;
      if (sim_done !== 1'b1 || wb_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL end_halt: got done=%b ready=%b expected 1 0", sim_done, wb_ready);
      end
      old_r5 = m_rf[5];
      e = mk(8'hB8, 2'd0, 4'd0, 4'd5, 64'h5555);
      apply_entry(e);
      wb_valid = 1'b1;
      repeat (5) @(negedge clk);
      wb_valid = 1'b0;
      n_checks++;
      if (regfile_o[5] !== old_r5) begin n_fail++; $display("FAIL end_no_write: got %h expected %h", regfile_o[5], old_r5); end
      n_checks++;
      if (retired_count !== m_count || rip_o !== m_rip) begin
         n_fail++;
         $display("FAIL end_frozen: got cnt=%0d rip=%h expected %0d %h", retired_count, rip_o, m_count, m_rip);
      end
      n_checks++;
      if (sim_done !== 1'b1 || wb_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL end_sticky: got done=%b ready=%b expected 1 0", sim_done, wb_ready);
      end
   endtask

   initial begin
      reset_n  = 1'b0;
      wb_valid = 1'b0;
      apply_entry('0);
      model_reset();
      test_reset();
      test_alu_write();
      test_imul();
      test_jump();
      test_flags();
      test_random();
      test_reset_mid_imul();
      test_sim_end();
      n_checks++;
      if (exp_q.size() != 0 || redir_q.size() != 0) begin
         n_fail++;
         $display("FAIL pending_pulses: got clr=%0d redir=%0d outstanding expected 0 0", exp_q.size(), redir_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mod_writeback.md
Name: mod_writeback

Overview:
- Consumer end of the EX/WB interface; the execute stage is the producer.
- Accepts one retired ALU result per handshake and commits it to the architectural state: the 16x64 register file, RFLAGS and RIP.
- For IMUL, writes the RDX:RAX pair over two cycles through the single write port.
- Raises the fetch redirect for taken conditional jumps, and drains and halts on sim_end.

Parameters:
- NREGS, 16, number of architectural 64-bit registers.
- RAX_IDX, 0, destination of the low IMUL half.
- RDX_IDX, 2, destination of the high IMUL half.
- FLAGS_RESET, 64'h2, RFLAGS reset value (res_1 = 1, all other bits 0).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wb_valid  in  1  EX/WB entry valid (execute's enable_writeback).
- wb_ready  out  1  block can accept an entry this cycle.
- opcode_exwb  in  8  primary opcode.
- dep_exwb  in  2  destination select: 2 selects regByte, anything else selects rmByte.
- regByte_exwb  in  4  ModRM reg field.
- rmByte_exwb  in  4  ModRM rm field.
- alu_result_exwb  in  64  result, or the low half for IMUL.
- alu_ext_result_exwb  in  64  high half (IMUL only).
- rip_exwb  in  64  next-sequential RIP of the instruction.
- jump_flag_exwb  in  1  conditional jump resolved taken.
- jump_target_exwb  in  64  taken-jump target.
- flags_valid_exwb  in  1  rflags_exwb must be committed.
- rflags_exwb  in  64  new flags (flags_reg layout).
- sim_end_exwb  in  1  last instruction.
- regfile_o  out  16x64  architectural register file, registered state.
- rflags_o  out  64  committed RFLAGS (execute's rflags_seq).
- rip_o  out  64  committed RIP.
- redirect_valid  out  1  one-cycle redirect pulse to fetch.
- redirect_target  out  64  redirect RIP.
- clr_valid  out  1  one-cycle scoreboard release pulse.
- clr_reg  out  4  register released by clr_valid.
- retired_count  out  64  number of retired instructions.
- sim_done  out  1  sticky halt indicator.

Behaviour:
- Reset (async, reset_n = 0):
  - regfile_o all 0; rflags_o = FLAGS_RESET; rip_o = 0; retired_count = 0.
  - All pulse outputs 0; sim_done = 0; FSM in IDLE.
  - Reset mid-WR_EXT abandons the RDX write.
- FSM states: IDLE, WR_EXT, HALT. wb_ready = (state == IDLE). An entry is accepted when wb_valid && wb_ready.
- Accept in IDLE, non-jump opcode (not 0x74 or 0x7D):
  - Destination dst = (dep_exwb == 2) ? regByte_exwb : rmByte_exwb.
  - At the edge: regfile[dst] <= alu_result_exwb; clr_valid = 1 and clr_reg = dst for the following cycle.
- Accept of 0xF7 (IMUL):
  - First edge: regfile[RAX_IDX] <= alu_result_exwb; latch the high half; go to WR_EXT; clr_valid for RAX.
  - WR_EXT edge: regfile[RDX_IDX] <= latched high half; clr_valid for RDX; return to IDLE, or to HALT if the latched sim_end was set.
  - Latency is 2 cycles, with wb_ready low for one cycle.
- Accept of 0x74 or 0x7D: no register write, no clr_valid.
  - If jump_flag_exwb: redirect_valid = 1 and redirect_target = jump_target_exwb the next cycle; rip_o <= jump_target_exwb.
  - Otherwise: rip_o <= rip_exwb.
- Every accept:
  - rip_o <= rip_exwb, except for a taken jump.
  - rflags_o <= rflags_exwb when flags_valid_exwb.
  - retired_count increments by 1 per instruction; IMUL counts once, at the first edge.
- sim_end:
  - An accept with sim_end_exwb commits normally, then the FSM goes to HALT (via WR_EXT for IMUL).
  - In HALT: sim_done = 1 (sticky), wb_ready = 0, no further state change until reset.
- Write/read ordering: writes become visible on regfile_o in the cycle after the edge. There is no internal bypass; hazards are covered by the decode scoreboard using clr_valid.
- wb_valid while wb_ready = 0 is ignored. The producer holds its entry until accepted.
- Pulse widths: redirect_valid and clr_valid are exactly one cycle per event. They are never asserted in HALT except for the final instruction's own commit.

Decomposition:
- Shared package (cpu_pkg):
  - flags_reg and MEM_EX typedefs, plus a new EX_WB packed struct.
  - Opcode constants: OPC_IMUL = 8'hF7, OPC_JE = 8'h74, OPC_JNL = 8'h7D.
  - RAX_IDX, RDX_IDX and FLAGS_RESET.
- One sub-module, mod_regfile: 16x64 array, single synchronous write port, async reset, full-array read output. The FSM, counter and redirect logic stay in mod_writeback.

Test Plan:
- Reset, then accept opcode 0xB8, dep = 0, rm = 3, result 0x1234 -> next cycle regfile_o[3] = 0x1234; clr_valid = 1 with clr_reg = 3; retired_count = 1; rflags_o = 0x2.
- Accept 0xF7, result 0x5, ext 0xFFFF_FFFF_FFFF_FFFF -> wb_ready low for one cycle; regfile[0] = 0x5, then regfile[2] = all ones; two clr pulses (reg 0, then reg 2); retired_count increments by 1.
- Accept 0x74 with jump_flag = 1, target 0x400100 -> redirect_valid for one cycle with target 0x400100; rip_o = 0x400100; no register change. Repeat with jump_flag = 0 and rip 0x400010 -> no redirect, rip_o = 0x400010.
- Accept with flags_valid = 1, rflags zf set (0x42) -> rflags_o = 0x42. A following entry with flags_valid = 0 leaves rflags_o at 0x42.
- Accept 0xF7 with sim_end = 1 -> both writes complete, then sim_done = 1 and wb_ready stays 0; further wb_valid has no effect on the regfile.
- Assert reset_n = 0 asynchronously during WR_EXT -> regfile cleared immediately, RDX not written, FSM in IDLE, wb_ready = 1 after release.
